id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register for the 16-bit, 16-register pipelined core, with integrated load-use hazard detection and bubble insertion. It sits directly upstream of the forwarding unit and the EX stage. It supplies the ID_EX_RegisterRs, ID_EX_RegisterRt and ID_EX_RegisterRd operand tags and the EX-stage control bits. It generates the Stall that holds the PC and IF/ID, and it counts stalls and flushes for performance debug.

Parameters:
DATA_W, 16, datapath width of operands, immediate and PC
REG_W, 4, register-specifier width (16 architectural registers; R0 reads as zero)
CNT_W, 16, width of the saturating stall and flush counters

Ports:
clk  in  1  single clock; all state updates on its rising edge
rst  in  1  synchronous, active-high reset
IF_ID_RegisterRs  in  REG_W  source 1 of the instruction in ID
IF_ID_RegisterRt  in  REG_W  source 2 of the instruction in ID
IF_ID_RegisterRd  in  REG_W  destination of the instruction in ID
IF_ID_UsesRs  in  1  ID instruction reads Rs
IF_ID_UsesRt  in  1  ID instruction reads Rt
IF_ID_IsStore  in  1  ID instruction is a store; Rt is its store data
IF_ID_Valid  in  1  ID holds a real instruction
ID_Regwrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_Halt  in  1 each  decoded control
ID_ALUOp  in  4  decoded ALU opcode
ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC  in  DATA_W each  operand, immediate and PC values
Flush  in  1  branch/jump redirect; squash the ID instruction
ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd  out  REG_W each  registered specifiers
ID_EX_Regwrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc, ID_EX_Halt  out  1 each  registered control
ID_EX_ALUOp  out  4  registered ALU opcode
ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_PC  out  DATA_W each  registered data
ID_EX_Valid  out  1  EX holds a real instruction
Stall  out  1  combinational; hold the PC and IF/ID this cycle
Halted  out  1  core has halted
StallCount, FlushCount  out  CNT_W each  saturating event counters

Behaviour:
- Reset (rst=1 at the edge):
  - all ID_EX_* outputs clear to 0, including Valid.
  - state returns to RUN.
  - both counters clear to 0.
  - Halted clears to 0.
  - Reset mid-stall or mid-halt discards everything; the next cycle is a clean RUN.
- Load-use hazard (combinational): LU = ID_EX_Valid & ID_EX_MemRead & (ID_EX_RegisterRd != 0) & IF_ID_Valid & (RsHit | RtHit).
  - RsHit = IF_ID_UsesRs & (ID_EX_RegisterRd == IF_ID_RegisterRs).
  - RtHit = IF_ID_UsesRt & ~IF_ID_IsStore & (ID_EX_RegisterRd == IF_ID_RegisterRt).
  - Load followed by a store that uses only the load result as store data does not stall; MEM-MEM forwarding covers it.
- Stall = LU & ~Flush & (state==RUN). Flush has priority over Stall.
- Register update each edge, by priority:
  1. rst.
  2. Flush, Stall, state!=RUN, or ~IF_ID_Valid: load a bubble. All control bits, Valid and the specifiers go to 0; data fields hold their previous values (don't-care).
  3. Otherwise: capture all ID_* inputs and set Valid=1.
- Latency: 1 cycle from ID inputs to ID_EX outputs. A load-use stall inserts exactly one bubble. On the next cycle the load is in MEM, LU is false, and the held ID instruction advances.
- State machine:
  - RUN: normal operation.
  - RUN -> DRAIN when an instruction with ID_Halt=1 is captured. Every later cycle loads bubbles; the halt itself proceeds down the pipe.
  - DRAIN -> HALTED after 3 further edges (EX, MEM, WB drain), counted by a 2-bit counter.
  - HALTED is sticky until rst; Halted=1 only in HALTED.
  - A Flush in the same cycle as the halt capture cancels it; state stays RUN.
- StallCount increments on every edge with Stall=1. FlushCount increments on every edge with Flush=1 & IF_ID_Valid. Both saturate at all-ones and never wrap.

Decomposition:
- Shared package cpu_pkg holds:
  - REG_W and DATA_W.
  - ALUOp encodings.
  - a control-bundle struct {Regwrite, MemRead, MemWrite, MemtoReg, ALUSrc, Halt, ALUOp} plus a CTRL_BUBBLE constant of all zeros.
  - the state enum {RUN, DRAIN, HALTED}.
- One natural sub-module: load_use_detect (pure combinational LU/Stall logic), reused by any future multi-issue variant.
- Counters stay inline.

Test Plan:
- LW R3 followed by ADD R5,R3,R4 -> Stall=1 for exactly 1 cycle; one bubble (Valid=0, Regwrite=0); ADD appears in ID_EX next cycle with Rs=3; StallCount=1.
- LW R3 followed by SW R3,0(R6) (Rt=3, IsStore=1, UsesRs=0) -> no stall; SW captured the next cycle; StallCount=0.
- LW R0 followed by ADD R1,R0,R0 -> no stall, since R0 never hazards.
- Load-use hazard with Flush=1 in the same cycle -> Stall=0, bubble loaded, FlushCount=1, StallCount unchanged.
- Halt captured -> Valid=0 on the following edges; Halted=1 exactly 4 edges after capture; stays 1 until rst; rst clears Halted, state and counters.
- Force 65535 stall events -> StallCount holds at 16'hFFFF on the next stall.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and widths for the 16-bit, 16-register pipelined core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: DATA_W/REG_W/CNT_W, ALU opcode encodings, the EX control
// bundle with its all-zero bubble value, and the ID/EX drain state enum.
package cpu_pkg;

   localparam int DATA_W = 16;
   localparam int REG_W  = 4;
   localparam int CNT_W  = 16;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SLL   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SLT   = 4'd7,
      ALU_PASSB = 4'd8
   } aluOpT;

   typedef struct packed {
      logic  regwrite;
      logic  memRead;
      logic  memWrite;
      logic  memtoReg;
      logic  aluSrc;
      logic  halt;
      aluOpT aluOp;
   } ctrlT;

   // A bubble is an instruction with every control bit cleared.
   localparam ctrlT CTRL_BUBBLE = '0;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } stateT;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of all ID-side inputs and EX-side outputs of the ID/EX stage.
// Latency: n/a (wires only).
// Backpressure: Stall (stage -> front end) holds the PC and IF/ID.
// Modports: master = the ID/EX stage itself, slave = decode/EX environment.
interface id_ex_stage_if;
   import cpu_pkg::*;

   // ID side
   logic [REG_W-1:0]  IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_RegisterRd;
   logic              IF_ID_UsesRs, IF_ID_UsesRt, IF_ID_IsStore, IF_ID_Valid;
   logic              ID_Regwrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_Halt;
   logic [3:0]        ID_ALUOp;
   logic [DATA_W-1:0] ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC;
   logic              Flush;

   // EX side and status
   logic [REG_W-1:0]  ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd;
   logic              ID_EX_Regwrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg;
   logic              ID_EX_ALUSrc, ID_EX_Halt;
   logic [3:0]        ID_EX_ALUOp;
   logic [DATA_W-1:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_PC;
   logic              ID_EX_Valid, Stall, Halted;
   logic [CNT_W-1:0]  StallCount, FlushCount;

   modport master (
      input  IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_RegisterRd,
             IF_ID_UsesRs, IF_ID_UsesRt, IF_ID_IsStore, IF_ID_Valid,
             ID_Regwrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_Halt,
             ID_ALUOp, ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC, Flush,
      output ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd,
             ID_EX_Regwrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg,
             ID_EX_ALUSrc, ID_EX_Halt, ID_EX_ALUOp,
             ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_PC,
             ID_EX_Valid, Stall, Halted, StallCount, FlushCount
   );

   modport slave (
      output IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_RegisterRd,
             IF_ID_UsesRs, IF_ID_UsesRt, IF_ID_IsStore, IF_ID_Valid,
             ID_Regwrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_Halt,
             ID_ALUOp, ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC, Flush,
      input  ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd,
             ID_EX_Regwrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg,
             ID_EX_ALUSrc, ID_EX_Halt, ID_EX_ALUOp,
             ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_PC,
             ID_EX_Valid, Stall, Halted, StallCount, FlushCount
   );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector: a load in EX whose result the ID instruction needs next cycle.
// Latency: purely combinational.
// Backpressure: produces stall; a flush or a non-RUN state suppresses it.
// Ports: EX-side load info (exValid/exMemRead/exRd), ID-side operand use
// (idValid/idUsesRs/idUsesRt/idIsStore/idRs/idRt), flush, isRun -> stall.
module load_use_detect
   import cpu_pkg::*;
(
   input  logic             exValid,
   input  logic             exMemRead,
   input  logic [REG_W-1:0] exRd,
   input  logic             idValid,
   input  logic             idUsesRs,
   input  logic             idUsesRt,
   input  logic             idIsStore,
   input  logic [REG_W-1:0] idRs,
   input  logic [REG_W-1:0] idRt,
   input  logic             flush,
   input  logic             isRun,
   output logic             stall
);
   logic rsHit;
   logic rtHit;
   logic loadUse;

   assign rsHit = idUsesRs & (exRd == idRs);
   // Store data (Rt) of a store is forwarded MEM->MEM, so it never needs a bubble.
   assign rtHit = idUsesRt & ~idIsStore & (exRd == idRt);
   // R0 is hardwired to zero, so a load into R0 never creates a dependency.
   assign loadUse = exValid & exMemRead & (exRd != '0) & idValid & (rsHit | rtHit);
   assign stall   = loadUse & ~flush & isRun;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, halt drain and event counters.
// Latency: 1 cycle from ID inputs to ID_EX outputs; Stall is combinational.
// Backpressure: Stall holds PC and IF/ID for one cycle while a bubble enters EX.
// Ports: clk, rst (sync, active-high), bus (id_ex_stage_if.master) carrying the
// decoded ID instruction in and the registered EX bundle, Stall, Halted and counters out.
module id_ex_stage
   import cpu_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   id_ex_stage_if.master bus
);
   stateT             state, stateNext;
   logic [1:0]        drainCnt;
   logic              stall, capture, isRun, halted;
   ctrlT              idCtrl, exCtrl;
   logic              exValid;
   logic [REG_W-1:0]  exRs, exRt, exRd;
   logic [DATA_W-1:0] exRd1, exRd2, exImm, exPc;
   logic [CNT_W-1:0]  stallCount, flushCount;

   load_use_detect u_lud (
      .exValid   (exValid),
      .exMemRead (exCtrl.memRead),
      .exRd      (exRd),
      .idValid   (bus.IF_ID_Valid),
      .idUsesRs  (bus.IF_ID_UsesRs),
      .idUsesRt  (bus.IF_ID_UsesRt),
      .idIsStore (bus.IF_ID_IsStore),
      .idRs      (bus.IF_ID_RegisterRs),
      .idRt      (bus.IF_ID_RegisterRt),
      .flush     (bus.Flush),
      .isRun     (isRun),
      .stall     (stall)
   );

   assign idCtrl = '{regwrite: bus.ID_Regwrite,
                     memRead:  bus.ID_MemRead,
                     memWrite: bus.ID_MemWrite,
                     memtoReg: bus.ID_MemtoReg,
                     aluSrc:   bus.ID_ALUSrc,
                     halt:     bus.ID_Halt,
                     aluOp:    aluOpT'(bus.ID_ALUOp)};

   // Anything other than a real, unflushed, unstalled instruction in RUN becomes a bubble.
   assign capture = bus.IF_ID_Valid & ~bus.Flush & ~stall & isRun;

   // FSM: state register (drainCnt counts the EX/MEM/WB drain edges)
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         drainCnt <= 2'd0;
      end else begin
         state    <= stateNext;
         drainCnt <= (state == DRAIN) ? drainCnt + 2'd1 : 2'd0;
      end
   end

   // FSM: next state. capture already excludes Flush, so a flushed halt stays in RUN.
   always_comb begin
      stateNext = state;
      case (state)
         RUN:     if (capture && idCtrl.halt) stateNext = DRAIN;
         DRAIN:   if (drainCnt == 2'd2) stateNext = HALTED;
         HALTED:  stateNext = HALTED;
         default: stateNext = RUN;
      endcase
   end

   // FSM: outputs
   always_comb begin
      isRun  = (state == RUN);
      halted = (state == HALTED);
   end

   // Pipeline register. Data fields are left untouched by bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         exCtrl  <= CTRL_BUBBLE;
         exValid <= 1'b0;
         exRs    <= '0;
         exRt    <= '0;
         exRd    <= '0;
         exRd1   <= '0;
         exRd2   <= '0;
         exImm   <= '0;
         exPc    <= '0;
      end else if (capture) begin
         exCtrl  <= idCtrl;
         exValid <= 1'b1;
         exRs    <= bus.IF_ID_RegisterRs;
         exRt    <= bus.IF_ID_RegisterRt;
         exRd    <= bus.IF_ID_RegisterRd;
         exRd1   <= bus.ID_ReadData1;
         exRd2   <= bus.ID_ReadData2;
         exImm   <= bus.ID_Imm;
         exPc    <= bus.ID_PC;
      end else begin
         exCtrl  <= CTRL_BUBBLE;
         exValid <= 1'b0;
         exRs    <= '0;
         exRt    <= '0;
         exRd    <= '0;
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk) begin
      if (rst) begin
         stallCount <= '0;
         flushCount <= '0;
      end else begin
         if (stall && stallCount != '1)
            stallCount <= stallCount + CNT_W'(1);
         if (bus.Flush && bus.IF_ID_Valid && flushCount != '1)
            flushCount <= flushCount + CNT_W'(1);
      end
   end

   assign bus.ID_EX_RegisterRs = exRs;
   assign bus.ID_EX_RegisterRt = exRt;
   assign bus.ID_EX_RegisterRd = exRd;
   assign bus.ID_EX_Regwrite   = exCtrl.regwrite;
   assign bus.ID_EX_MemRead    = exCtrl.memRead;
   assign bus.ID_EX_MemWrite   = exCtrl.memWrite;
   assign bus.ID_EX_MemtoReg   = exCtrl.memtoReg;
   assign bus.ID_EX_ALUSrc     = exCtrl.aluSrc;
   assign bus.ID_EX_Halt       = exCtrl.halt;
   assign bus.ID_EX_ALUOp      = exCtrl.aluOp;
   assign bus.ID_EX_ReadData1  = exRd1;
   assign bus.ID_EX_ReadData2  = exRd2;
   assign bus.ID_EX_Imm        = exImm;
   assign bus.ID_EX_PC         = exPc;
   assign bus.ID_EX_Valid      = exValid;
   assign bus.Stall            = stall;
   assign bus.Halted           = halted;
   assign bus.StallCount       = stallCount;
   assign bus.FlushCount       = flushCount;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load-use stall, store exemption, R0, flush priority,
// halt drain, reset recovery and counter saturation, all with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_id_ex_stage;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   passed = 0;
   int   total  = 0;

   id_ex_stage_if bus ();

   id_ex_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearIn();
      bus.IF_ID_RegisterRs = '0; bus.IF_ID_RegisterRt = '0; bus.IF_ID_RegisterRd = '0;
      bus.IF_ID_UsesRs = 1'b0; bus.IF_ID_UsesRt = 1'b0; bus.IF_ID_IsStore = 1'b0;
      bus.IF_ID_Valid = 1'b0;
      bus.ID_Regwrite = 1'b0; bus.ID_MemRead = 1'b0; bus.ID_MemWrite = 1'b0;
      bus.ID_MemtoReg = 1'b0; bus.ID_ALUSrc = 1'b0; bus.ID_Halt = 1'b0;
      bus.ID_ALUOp = 4'd0;
      bus.ID_ReadData1 = '0; bus.ID_ReadData2 = '0; bus.ID_Imm = '0; bus.ID_PC = '0;
      bus.Flush = 1'b0;
   endtask

   // LW rd, 4(rs)
   task automatic setLw(input logic [3:0] rd, input logic [3:0] rs, input logic [15:0] pc);
      clearIn();
      bus.IF_ID_Valid = 1'b1; bus.IF_ID_RegisterRd = rd; bus.IF_ID_RegisterRs = rs;
      bus.IF_ID_UsesRs = 1'b1; bus.ID_Regwrite = 1'b1; bus.ID_MemRead = 1'b1;
      bus.ID_MemtoReg = 1'b1; bus.ID_ALUSrc = 1'b1; bus.ID_Imm = 16'd4; bus.ID_PC = pc;
   endtask

   // ADD rd, rs, rt
   task automatic setAdd(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt,
                         input logic [15:0] pc);
      clearIn();
      bus.IF_ID_Valid = 1'b1; bus.IF_ID_RegisterRd = rd; bus.IF_ID_RegisterRs = rs;
      bus.IF_ID_RegisterRt = rt; bus.IF_ID_UsesRs = 1'b1; bus.IF_ID_UsesRt = 1'b1;
      bus.ID_Regwrite = 1'b1; bus.ID_ALUOp = 4'd0;
      bus.ID_ReadData1 = 16'h1111; bus.ID_ReadData2 = 16'h2222; bus.ID_PC = pc;
   endtask

   initial begin
      clearIn();
      // ---- reset ----
      rst = 1'b1;
      tick(); tick();
      chk("rst_valid", bus.ID_EX_Valid, 0);
      chk("rst_regwrite", bus.ID_EX_Regwrite, 0);
      chk("rst_pc", bus.ID_EX_PC, 0);
      chk("rst_halted", bus.Halted, 0);
      chk("rst_stallcnt", bus.StallCount, 0);
      rst = 1'b0;

      // ---- LW R3 then ADD R5,R3,R4: one stall, one bubble ----
      setLw(4'd3, 4'd2, 16'h0010);
      #1 chk("lw_nostall", bus.Stall, 0);
      tick();
      chk("lw_memread", bus.ID_EX_MemRead, 1);
      chk("lw_rd", bus.ID_EX_RegisterRd, 3);
      setAdd(4'd5, 4'd3, 4'd4, 16'h0012);
      #1 chk("lu_stall", bus.Stall, 1);
      tick();
      chk("bubble_valid", bus.ID_EX_Valid, 0);
      chk("bubble_regwrite", bus.ID_EX_Regwrite, 0);
      chk("bubble_rs", bus.ID_EX_RegisterRs, 0);
      chk("lu_stallcnt", bus.StallCount, 1);
      #1 chk("lu_stall_released", bus.Stall, 0);
      tick();
      chk("add_valid", bus.ID_EX_Valid, 1);
      chk("add_rs", bus.ID_EX_RegisterRs, 3);
      chk("add_rt", bus.ID_EX_RegisterRt, 4);
      chk("add_rd", bus.ID_EX_RegisterRd, 5);
      chk("add_pc", bus.ID_EX_PC, 16'h0012);
      chk("add_rd1", bus.ID_EX_ReadData1, 16'h1111);
      chk("add_stallcnt", bus.StallCount, 1);

      // ---- LW R3 then SW R3,0(R6): store data dependency does not stall ----
      setLw(4'd3, 4'd2, 16'h0020);
      tick();
      clearIn();
      bus.IF_ID_Valid = 1'b1; bus.IF_ID_RegisterRs = 4'd6; bus.IF_ID_RegisterRt = 4'd3;
      bus.IF_ID_UsesRs = 1'b1; bus.IF_ID_UsesRt = 1'b1; bus.IF_ID_IsStore = 1'b1;
      bus.ID_MemWrite = 1'b1; bus.ID_ALUSrc = 1'b1; bus.ID_PC = 16'h0022;
      #1 chk("sw_nostall", bus.Stall, 0);
      tick();
      chk("sw_valid", bus.ID_EX_Valid, 1);
      chk("sw_memwrite", bus.ID_EX_MemWrite, 1);
      chk("sw_rt", bus.ID_EX_RegisterRt, 3);
      chk("sw_stallcnt", bus.StallCount, 1);

      // ---- LW R0 then ADD R1,R0,R0: R0 never hazards ----
      setLw(4'd0, 4'd2, 16'h0030);
      tick();
      setAdd(4'd1, 4'd0, 4'd0, 16'h0032);
      #1 chk("r0_nostall", bus.Stall, 0);
      tick();
      chk("r0_valid", bus.ID_EX_Valid, 1);
      chk("r0_rd", bus.ID_EX_RegisterRd, 1);

      // ---- hazard with Flush: flush wins ----
      setLw(4'd3, 4'd2, 16'h0040);
      tick();
      setAdd(4'd5, 4'd3, 4'd4, 16'h0042);
      bus.Flush = 1'b1;
      #1 chk("flush_nostall", bus.Stall, 0);
      tick();
      chk("flush_bubble", bus.ID_EX_Valid, 0);
      chk("flush_cnt", bus.FlushCount, 1);
      chk("flush_stallcnt", bus.StallCount, 1);
      // Flush with no valid instruction in ID is not counted
      clearIn();
      bus.Flush = 1'b1;
      tick();
      chk("flush_invalid_cnt", bus.FlushCount, 1);

      // ---- halt cancelled by a same-cycle flush ----
      clearIn();
      bus.IF_ID_Valid = 1'b1; bus.ID_Halt = 1'b1; bus.Flush = 1'b1;
      tick();
      chk("halt_flush_bubble", bus.ID_EX_Valid, 0);
      setAdd(4'd7, 4'd1, 4'd2, 16'h0050);
      tick();
      chk("halt_cancel_run", bus.ID_EX_Valid, 1);
      chk("halt_flush_cnt", bus.FlushCount, 2);

      // ---- halt drain: capture edge plus three drain edges ----
      clearIn();
      bus.IF_ID_Valid = 1'b1; bus.ID_Halt = 1'b1; bus.ID_PC = 16'h0060;
      tick();
      chk("halt_capture", bus.ID_EX_Halt, 1);
      chk("halt_cap_valid", bus.ID_EX_Valid, 1);
      chk("halted_e0", bus.Halted, 0);
      setAdd(4'd7, 4'd1, 4'd2, 16'h0062);
      tick();
      chk("drain_e1_valid", bus.ID_EX_Valid, 0);
      chk("halted_e1", bus.Halted, 0);
      tick();
      chk("halted_e2", bus.Halted, 0);
      tick();
      chk("halted_e3", bus.Halted, 1);
      chk("halted_valid", bus.ID_EX_Valid, 0);
      tick(); tick();
      chk("halted_sticky", bus.Halted, 1);

      // ---- reset out of HALTED ----
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2_halted", bus.Halted, 0);
      chk("rst2_stallcnt", bus.StallCount, 0);
      chk("rst2_flushcnt", bus.FlushCount, 0);
      chk("rst2_valid", bus.ID_EX_Valid, 0);
      tick();
      chk("rst2_run_capture", bus.ID_EX_Valid, 1);

      // ---- stall counter saturation: preload to one below all-ones ----
      force dut.stallCount = 16'hFFFE;
      #1;
      release dut.stallCount;
      setLw(4'd3, 4'd2, 16'h0070);
      tick();
      setAdd(4'd5, 4'd3, 4'd4, 16'h0072);
      tick();
      chk("sat_reach", bus.StallCount, 16'hFFFF);
      tick();
      setLw(4'd3, 4'd2, 16'h0074);
      tick();
      setAdd(4'd5, 4'd3, 4'd4, 16'h0076);
      #1 chk("sat_stall", bus.Stall, 1);
      tick();
      chk("sat_hold", bus.StallCount, 16'hFFFF);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
